// File: rtl/l2_pkg.sv
// l2_pkg -- shared types and constants for the L2 AXI-lite memory slave. Rev 1.0
`default_nettype none

package l2_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Wide enough for RD_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/l2_sram.sv
// l2_sram -- word array with byte-lane writes and a registered read port. Rev 1.0
`default_nettype none

module l2_sram #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [XLEN-1:0]                wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [XLEN-1:0]                rdata
);

  localparam int LANE = XLEN / 4;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
        end
      end
    end
  end

  // Non-blocking read of the array gives pre-write data on a same-edge collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_axi_mem.sv
// l2_axi_mem -- single-beat AXI-lite slave over l2_sram; define L2_MEM_ADDR_CHECK_EN
// to reject addresses beyond the backing store. Rev 1.0
`default_nettype none

module l2_axi_mem
  import l2_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] axi_awaddr,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [XLEN-1:0] axi_wdata,
  input  logic [3:0]      axi_wstrb,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  input  logic [XLEN-1:0] axi_araddr,
  input  logic            axi_arvalid,
  output logic            axi_arready,
  output logic [XLEN-1:0] axi_rdata,
  output logic            axi_rvalid,
  input  logic            axi_rready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  rd_state_e        rd_state, rd_state_nxt;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_sample;
  logic             ar_hs;

  logic             aw_held, w_held;
  logic [IDX_W-1:0] aw_idx;
  logic [XLEN-1:0]  w_data;
  logic [3:0]       w_strb;
  logic             commit;
  logic             mem_we;
  logic [XLEN-1:0]  sram_rdata;
  logic             rd_oor, aw_oor;
  logic             unused_addr_bits;

  assign ar_hs = axi_arvalid & axi_arready;

  always_comb begin
    rd_state_nxt = rd_state;
    rd_cnt_nxt   = rd_cnt;
    rd_sample    = 1'b0;
    axi_arready  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        axi_arready = 1'b1;
        if (axi_arvalid) begin
          rd_state_nxt = RD_WAIT;
          rd_cnt_nxt   = CNT_W'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (rd_cnt == '0) begin
          rd_sample    = 1'b1;
          rd_state_nxt = RD_RESP;
        end else begin
          rd_cnt_nxt = rd_cnt - CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (axi_rready) begin
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_idx   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      if (ar_hs) begin
        rd_idx <= axi_araddr[IDX_W+1:2];
      end
    end
  end

  assign axi_rvalid  = (rd_state == RD_RESP);
  assign axi_awready = ~aw_held & ~axi_bvalid;
  assign axi_wready  = ~w_held & ~axi_bvalid;
  assign commit      = aw_held & w_held & ~axi_bvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      axi_bvalid <= 1'b0;
      aw_idx     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
    end else if (axi_bvalid & axi_bready) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      axi_bvalid <= 1'b0;
    end else begin
      if (axi_awvalid & axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= axi_awaddr[IDX_W+1:2];
      end
      if (axi_wvalid & axi_wready) begin
        w_held <= 1'b1;
        w_data <= axi_wdata;
        w_strb <= axi_wstrb;
      end
      if (commit) begin
        axi_bvalid <= 1'b1;
      end
    end
  end

`ifdef L2_MEM_ADDR_CHECK_EN
  // Out-of-range flags travel with the held address so the response stays consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_oor <= 1'b0;
      aw_oor <= 1'b0;
    end else begin
      if (ar_hs) begin
        rd_oor <= |axi_araddr[XLEN-1:IDX_W+2];
      end
      if (axi_awvalid & axi_awready) begin
        aw_oor <= |axi_awaddr[XLEN-1:IDX_W+2];
      end
    end
  end
  assign mem_we           = commit & ~aw_oor;
  assign axi_rdata        = rd_oor ? XLEN'(DEAD_BEEF) : sram_rdata;
  assign unused_addr_bits = ^{axi_araddr[1:0], axi_awaddr[1:0]};
`else
  assign rd_oor           = 1'b0;
  assign aw_oor           = 1'b0;
  assign mem_we           = commit & ~aw_oor;
  assign axi_rdata        = rd_oor ? XLEN'(DEAD_BEEF) : sram_rdata;
  assign unused_addr_bits = ^{axi_araddr[1:0], axi_awaddr[1:0],
                              axi_araddr[XLEN-1:IDX_W+2], axi_awaddr[XLEN-1:IDX_W+2]};
`endif

  l2_sram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .be    (w_strb),
    .waddr (aw_idx),
    .wdata (w_data),
    .re    (rd_sample),
    .raddr (rd_idx),
    .rdata (sram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_l2_axi_mem.sv
// tb_l2_axi_mem -- randomized and directed checks of l2_axi_mem against a word-array model.
`default_nettype none
`timescale 1ns/1ps

module tb_l2_axi_mem;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int NW     = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] awaddr, wdata, araddr, rdata;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;
  logic            arvalid, arready, rvalid, rready;

  l2_axi_mem #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .axi_awaddr  (awaddr),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .axi_araddr  (araddr),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_rdata   (rdata),
    .axi_rvalid  (rvalid),
    .axi_rready  (rready)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef L2_MEM_ADDR_CHECK_EN
    return a[31:12] != 20'd0;
`else
    return a[31:12] != a[31:12];
`endif
  endfunction

  function automatic logic [31:0] expect_rd(input logic [31:0] a);
    return oor(a) ? 32'hDEAD_BEEF : model[widx(a)];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdelay);
    int t_aw, t_w, t;
    bit aw_done, w_done, hs_aw, hs_w;
    t_aw = (lead > 0) ? lead : 0;
    t_w  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 20) begin
      if (!aw_done && t >= t_aw) begin awvalid = 1'b1; awaddr = a; end
      if (!w_done && t >= t_w) begin wvalid = 1'b1; wdata = d; wstrb = s; end
      hs_aw = awvalid & awready;
      hs_w  = wvalid & wready;
      tick;
      if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  wvalid = 1'b0; end
      t++;
    end
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 32'd0, 32'd1);
    check("bvalid_before_commit", 32'(bvalid), 32'd0);
    tick;
    check("bvalid_after_commit", 32'(bvalid), 32'd1);
    for (int i = 0; i < bdelay; i++) begin
      check("awready_while_b", 32'(awready), 32'd0);
      check("wready_while_b", 32'(wready), 32'd0);
      check("bvalid_hold", 32'(bvalid), 32'd1);
      tick;
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    check("bvalid_cleared", 32'(bvalid), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
    check("wready_after_b", 32'(wready), 32'd1);
    if (!oor(a)) model[widx(a)] = merge(model[widx(a)], d, s);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay, input logic [31:0] exp);
    int lat;
    arvalid = 1'b1;
    araddr  = a;
    check("arready_idle", 32'(arready), 32'd1);
    tick;
    arvalid = 1'b0;
    check("arready_after_ar", 32'(arready), 32'd0);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick;
      lat++;
    end
    check("rd_latency", 32'(lat), 32'(RD_LAT));
    check("rdata", rdata, exp);
    // A competing AR stays asserted through the hold and the R handshake.
    arvalid = 1'b1;
    araddr  = $urandom;
    for (int i = 0; i < rdelay; i++) begin
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp);
      check("arready_busy", 32'(arready), 32'd0);
      tick;
    end
    rready = 1'b1;
    tick;
    rready  = 1'b0;
    arvalid = 1'b0;
    check("rvalid_cleared", 32'(rvalid), 32'd0);
    check("ar_not_taken_on_r", 32'(arready), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr;
    logic [31:0] up;
    up = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : 32'd0;
    return (up << 12) | (32'($urandom_range(0, NW - 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    tick; tick;
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < NW; i++) axi_write(32'(i) << 2, $urandom, 4'hF, 0, 0);

    axi_write(32'h40, 32'h1234_5678, 4'hF, 0, 0);
    axi_read(32'h40, 0, 32'h1234_5678);

    axi_write(32'h44, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(32'h44, 32'hAAAA_BBBB, 4'b0011, 2, 0);
    axi_read(32'h44, 0, 32'hFFFF_BBBB);

    axi_read(32'h44, 5, 32'hFFFF_BBBB);
    axi_write(32'h48, 32'hCAFE_0001, 4'hF, -1, 5);
    axi_read(32'h48, 1, 32'hCAFE_0001);

    // Write commit and read sample land on the same edge.
    axi_write(32'h80, 32'h1, 4'hF, 0, 0);
    araddr = 32'h80; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    for (int i = 0; i < RD_LAT - 2; i++) tick;
    awaddr = 32'h80; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    tick;
    check("collide_rvalid", 32'(rvalid), 32'd1);
    check("collide_bvalid", 32'(bvalid), 32'd1);
    check("collide_old_data", rdata, 32'h1);
    bready = 1'b1; rready = 1'b1;
    tick;
    bready = 1'b0; rready = 1'b0;
    model[32] = 32'h2;
    axi_read(32'h80, 0, 32'h2);

    // Reset with a read waiting and only AW held.
    axi_write(32'h100, 32'h5555_AAAA, 4'hF, 0, 0);
    araddr = 32'h100; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    awaddr = 32'h100; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    check("aw_held_blocks", 32'(awready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_bvalid", 32'(bvalid), 32'd0);
    check("midrst_arready", 32'(arready), 32'd1);
    check("midrst_awready", 32'(awready), 32'd1);
    check("midrst_wready", 32'(wready), 32'd1);
    tick;
    rst = 1'b0;
    tick;
    axi_read(32'h100, 0, 32'h5555_AAAA);

    axi_read(32'h0001_0000, 0, expect_rd(32'h0001_0000));
    axi_write(32'h0001_0004, 32'h0BAD_F00D, 4'hF, 0, 0);
    axi_read(32'h4, 0, model[1]);

    for (int n = 0; n < 80; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2,
                  $urandom_range(0, 3));
      end else begin
        axi_read(a, $urandom_range(0, 3), expect_rd(a));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
